// File: rtl/decode_pipe.sv
// decode_pipe: single-stage RISC-V style instruction decode with register file,
// write-through bypass, load-use hazard stall and a valid/ready output register.
module decode_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            req,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            wb_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_value,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd_out,
  output logic            rd_write_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [XLEN-1:0] rs1_value_out,
  output logic [XLEN-1:0] rs2_value_out,
  output logic [XLEN-1:0] imm_value_out,
  output logic            illegal_out,
  output logic [31:0]     stall_count
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IOP  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_S    = 7'b0100011;

  // True when a 5-bit register index names an implemented register.
  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_W;
  endfunction

  // ---------------------------------------------------------------------------
  // Field extraction and instruction class
  // ---------------------------------------------------------------------------
  logic [6:0] opc;
  logic [4:0] rd_idx, rs1_idx, rs2_idx;
  logic       is_r, is_iop, is_load, is_u, is_b, is_j, is_s;
  logic       known, use_rs1, use_rs2, has_rd;
  logic       illegal, rd_write;

  assign opc     = instr_in[6:0];
  assign rd_idx  = instr_in[11:7];
  assign rs1_idx = instr_in[19:15];
  assign rs2_idx = instr_in[24:20];

  assign is_r    = (opc == OP_R);
  assign is_iop  = (opc == OP_IOP);
  assign is_load = (opc == OP_LOAD);
  assign is_u    = (opc == OP_U);
  assign is_b    = (opc == OP_B);
  assign is_j    = (opc == OP_J);
  assign is_s    = (opc == OP_S);

  assign known   = is_r | is_iop | is_load | is_u | is_b | is_j | is_s;
  assign use_rs1 = is_r | is_iop | is_load | is_s | is_b;
  assign use_rs2 = is_r | is_s | is_b;
  assign has_rd  = is_r | is_iop | is_load | is_u | is_j;

  // An out-of-range index is only an error where the field is actually a
  // register; for S/B the rd bits are immediate bits and are not checked.
  assign illegal = !known
                 | (use_rs1 & !in_range(rs1_idx))
                 | (use_rs2 & !in_range(rs2_idx))
                 | (has_rd  & !in_range(rd_idx));

  assign rd_write = has_rd & (rd_idx != 5'd0) & !illegal;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rf [NREGS];

  // Register-file write port; entry 0 is never written so x0 stays zero.
  // NOTE: the array is reset like any other flop here because every entry
  // must read 0 after reset; that forces flops rather than an SRAM macro.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_write && (wb_rd != 5'd0) && in_range(wb_rd)) begin
      rf[wb_rd[AW-1:0]] <= wb_value;
    end
  end

  // Source operand reads: unused, x0 and out-of-range sources read 0, and a
  // same-cycle writeback to the source is forwarded.
  logic            rs1_ok, rs2_ok;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign rs1_ok  = use_rs1 & (rs1_idx != 5'd0) & in_range(rs1_idx);
  assign rs2_ok  = use_rs2 & (rs2_idx != 5'd0) & in_range(rs2_idx);
  assign rs1_val = !rs1_ok                        ? '0
                 : (wb_write && wb_rd == rs1_idx) ? wb_value
                 :                                  rf[rs1_idx[AW-1:0]];
  assign rs2_val = !rs2_ok                        ? '0
                 : (wb_write && wb_rd == rs2_idx) ? wb_value
                 :                                  rf[rs2_idx[AW-1:0]];

  // ---------------------------------------------------------------------------
  // Immediate generation
  // ---------------------------------------------------------------------------
  logic        [31:0]     imm32;
  logic        [XLEN-1:0] imm_val;

  // Build the 32-bit sign-extended immediate for the decoded format.
  // NOTE: imm32 gets a default before any branch so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    imm32 = '0;
    if (!illegal) begin
      if (is_iop || is_load)
        imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      else if (is_s)
        imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      else if (is_b)
        imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                 instr_in[30:25], instr_in[11:8], 1'b0};
      else if (is_u)
        imm32 = {instr_in[31:12], 12'b0};
      else if (is_j)
        imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                 instr_in[20], instr_in[30:21], 1'b0};
    end
  end

  assign imm_val = XLEN'($signed(imm32));

  // ---------------------------------------------------------------------------
  // Hazard and handshake
  // ---------------------------------------------------------------------------
  logic load_pending, hazard, accept;

  assign load_pending = out_valid & (opcode_out == OP_LOAD) & (rd_out != 5'd0);
  assign hazard       = load_pending
                      & ((use_rs1 & (rs1_idx == rd_out))
                       | (use_rs2 & (rs2_idx == rd_out)));
  assign in_ready     = !flush & !hazard & (!out_valid | out_ready);
  assign accept       = in_valid & in_ready;

  // Output bundle register: load on accept, drop on consume or flush, else hold.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      pc_out        <= '0;
      rd_out        <= '0;
      rd_write_out  <= 1'b0;
      opcode_out    <= '0;
      funct3_out    <= '0;
      funct7_out    <= '0;
      rs1_value_out <= '0;
      rs2_value_out <= '0;
      imm_value_out <= '0;
      illegal_out   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      pc_out        <= pc_in;
      rd_out        <= rd_idx;
      rd_write_out  <= rd_write;
      opcode_out    <= opc;
      funct3_out    <= instr_in[14:12];
      funct7_out    <= instr_in[31:25];
      rs1_value_out <= rs1_val;
      rs2_value_out <= rs2_val;
      imm_value_out <= imm_val;
      illegal_out   <= illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was held by a load-use hazard.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (in_valid && hazard && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter NREGS, default 32, architectural register count; legal values 16 (RV32E mode) and 32.
REQ-003 Port req  in  1  clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  reset; asynchronous, active-high.
REQ-005 Port in_valid  in  1  instruction presented at decode input.
REQ-006 Port in_ready  out  1  decode accepts the input this cycle.
REQ-007 Port instr_in  in  32  instruction word.
REQ-008 Port pc_in  in  XLEN  instruction PC.
REQ-009 Port flush  in  1  kill the held output and refuse input this cycle.
REQ-010 Ports wb_write  in  1, wb_rd  in  5, wb_value  in  XLEN  register-file write port.
REQ-011 Port out_valid  out  1  decoded bundle valid; out_ready  in  1  downstream accepts.
REQ-012 Ports pc_out  out  XLEN; rd_out  out  5; rd_write_out  out  1; opcode_out  out  7; funct3_out  out  3; funct7_out  out  7.
REQ-013 Ports rs1_value_out, rs2_value_out, imm_value_out  out  XLEN; illegal_out  out  1.
REQ-014 Port stall_count  out  32  count of load-use stall cycles.

Function
REQ-015 Supported opcodes: R 0110011, I-op 0010011, I-load 0000011, U 0110111, B 1100011, J 1101111, S 0100011; any other opcode is illegal.
REQ-016 rs1 = instr[19:15], used by R, I-op, I-load, S, B; rs2 = instr[24:20], used by R, S, B; an unused source reads 0.
REQ-017 Register file: NREGS x XLEN; x0 reads 0; write on req edge when wb_write=1, wb_rd!=0, wb_rd<NREGS.
REQ-018 Reads are combinational with write-through bypass: same-cycle wb_write to a used, nonzero rs returns wb_value.
REQ-019 A used rs, or rd, with index >= NREGS sets illegal; that source reads 0.
REQ-020 Immediates are sign-extended to XLEN: I [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R and illegal 0.
REQ-021 funct3_out = instr[14:12], funct7_out = instr[31:25], opcode_out = instr[6:0], unmodified for every opcode.
REQ-022 rd_write_out = 1 only for R, I-op, I-load, U, J with rd!=0 and not illegal.
REQ-023 Illegal instructions propagate with illegal_out=1 and rd_write_out=0.
REQ-024 Hazard = out_valid, opcode_out=I-load, rd_out!=0, and rd_out equals a used rs of instr_in.
REQ-025 in_ready = !flush and !hazard and (!out_valid or out_ready).
REQ-026 Accept (in_valid and in_ready) loads all output registers on the next edge, sets out_valid=1; latency is 1 cycle.
REQ-027 out_valid=1 and out_ready=1 with no accept clears out_valid; with accept, the new bundle replaces the old one in the same edge.
REQ-028 out_valid=1 and out_ready=0 holds every output stable.
REQ-029 flush=1 clears out_valid on the next edge regardless of out_ready or in_valid; the register-file write still occurs.
REQ-030 stall_count increments on each edge with in_valid=1 and hazard=1; it saturates at 0xFFFFFFFF.

Reset
REQ-031 reset=1 asynchronously clears out_valid, all output registers, stall_count, and every register-file entry to 0.
REQ-032 Deasserting reset mid-operation resumes from the empty state; no pre-reset instruction reappears.

Verification
REQ-033 Reset, then write x5=0x1234, then issue ADDI x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, rs1_value_out=0x1234, imm_value_out=0xFFFFFFFF, rd_out=6, rd_write_out=1.
REQ-034 Issue ADD x7,x5,x5 in the same cycle as wb_write x5=0x10 -> rs1_value_out=rs2_value_out=0x10 (bypass).
REQ-035 Issue LW x8,0(x1), then ADD x9,x8,x2 -> in_ready=0 for exactly 1 cycle, stall_count=1, then ADD accepted.
REQ-036 Hold out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged; in_ready=0; flush then gives out_valid=0 next cycle.
REQ-037 Set NREGS=16 and issue ADD x1,x20,x2 -> illegal_out=1, rs1_value_out=0, rd_write_out=0.
REQ-038 Assert reset asynchronously while out_valid=1 -> out_valid=0 and stall_count=0 immediately, without waiting for a req edge.
